// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer and its length decoder.
// State encoding, opcode length-field codes and instruction word width.
package instruction_fetch_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int INSTR_W    = 3 * DATA_W_DEF;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_A  = 2'd1,
        FETCH_B  = 2'd2,
        HOLD     = 2'd3
    } fetch_state_e;

    // Top two opcode bits select the instruction length; anything else is 3 bytes.
    localparam logic [1:0] LEN_1 = 2'b00;
    localparam logic [1:0] LEN_2 = 2'b01;

    function automatic int instr_width(input int data_w);
        return 3 * data_w;
    endfunction

endpackage

// File: rtl/instruction_fetch_ctrl_len_decode.sv
// Maps the opcode length field (opcode[7:6]) to the instruction byte count 1..3.
// Purely combinational so the decoder can reuse it on an already captured opcode.
module instr_len_decode
    import instruction_fetch_ctrl_pkg::*;
(
    input  logic [1:0] len_field,
    output logic [1:0] byte_cnt
);

    always_comb begin
        byte_cnt = 2'd3;
        case (len_field)
            LEN_1:   byte_cnt = 2'd1;
            LEN_2:   byte_cnt = 2'd2;
            default: byte_cnt = 2'd3;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Byte-serial instruction fetch: reads opcode plus 0-2 operands over a req/ready
// memory handshake, presents the 24-bit word to decode, and owns the PC.
module instruction_fetch_ctrl
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           mem_ready,
    output logic [DATA_W-1:0]              opcode,
    output logic [DATA_W-1:0]              operando1,
    output logic [DATA_W-1:0]              operando2,
    output logic [instr_width(DATA_W)-1:0] instReg,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    input  logic                           pc_load,
    input  logic [ADDR_W-1:0]              pc_load_value,
    output logic [ADDR_W-1:0]              pc
);

    fetch_state_e      state_q, state_d;
    fetch_state_e      next_fetch;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] operando1_q, operando1_d;
    logic [DATA_W-1:0] operando2_q, operando2_d;
    logic              instr_valid_q, instr_valid_d;
    logic [1:0]        len_field;
    logic [1:0]        byte_cnt;

    // In FETCH_OP the length comes from the byte being captured this edge;
    // afterwards it comes from the registered opcode.
    assign len_field = (state_q == FETCH_OP) ? mem_data[DATA_W-1 -: 2]
                                             : opcode_q[DATA_W-1 -: 2];

    instr_len_decode u_len_decode (
        .len_field (len_field),
        .byte_cnt  (byte_cnt)
    );

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        next_fetch = HOLD;
        case (state_q)
            FETCH_OP: next_fetch = (byte_cnt > 2'd1) ? FETCH_A : HOLD;
            FETCH_A:  next_fetch = (byte_cnt == 2'd3) ? FETCH_B : HOLD;
            default:  next_fetch = HOLD;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_rd_d      = mem_rd_q;
        mem_addr_d    = mem_addr_q;
        opcode_d      = opcode_q;
        operando1_d   = operando1_q;
        operando2_d   = operando2_q;
        instr_valid_d = instr_valid_q;

        if (pc_load) begin
            // Jump/branch: drop any partial fetch; byte registers keep stale data.
            pc_d          = pc_load_value;
            instr_valid_d = 1'b0;
            mem_rd_d      = 1'b0;
            state_d       = FETCH_OP;
        end else begin
            case (state_q)
                FETCH_OP, FETCH_A, FETCH_B: begin
                    if (!mem_rd_q) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc_q;
                    end else if (mem_ready) begin
                        pc_d       = pc_inc;
                        mem_addr_d = pc_inc;
                        state_d    = next_fetch;
                        case (state_q)
                            FETCH_OP: begin
                                opcode_d    = mem_data;
                                operando1_d = '0;
                                operando2_d = '0;
                            end
                            FETCH_A: operando1_d = mem_data;
                            default: operando2_d = mem_data;
                        endcase
                        if (next_fetch == HOLD) begin
                            mem_rd_d      = 1'b0;
                            instr_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    mem_rd_d = 1'b0;
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = FETCH_OP;
                        mem_rd_d      = 1'b1;
                        mem_addr_d    = pc_q;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_OP;
            pc_q          <= RESET_PC;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            opcode_q      <= '0;
            operando1_q   <= '0;
            operando2_q   <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_rd_q      <= mem_rd_d;
            mem_addr_q    <= mem_addr_d;
            opcode_q      <= opcode_d;
            operando1_q   <= operando1_d;
            operando2_q   <= operando2_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign opcode      = opcode_q;
    assign operando1   = operando1_q;
    assign operando2   = operando2_q;
    assign instReg     = {opcode_q, operando1_q, operando2_q};
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;

endmodule

// File: doc/instruction_fetch_ctrl.md
Name: instruction_fetch_ctrl

Overview:
Fetch sequencer feeding the instruction register. Reads an instruction byte-by-byte from program memory over a req/ready handshake: opcode first, then 0–2 operand bytes. The operand count is set by the opcode. It assembles {opcode, operando1, operando2} into a 24-bit word and presents it to decode with a valid/ready handshake. It owns the program counter and accepts a PC reload for jumps and branches.

Parameters:
DATA_W, 8, width of opcode and each operand byte
ADDR_W, 8, program memory address width / PC width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_rd  out  1  memory read request
mem_addr  out  ADDR_W  byte address of current request
mem_data  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  memory completes the read this cycle
opcode  out  DATA_W  captured opcode byte
operando1  out  DATA_W  captured first operand (0 if unused)
operando2  out  DATA_W  captured second operand (0 if unused)
instReg  out  3*DATA_W  {opcode, operando1, operando2}
instr_valid  out  1  instReg holds a complete instruction
instr_ready  in  1  decode accepts instReg this cycle
pc_load  in  1  reload PC (jump/branch), aborts current fetch
pc_load_value  in  ADDR_W  new PC
pc  out  ADDR_W  address of the next byte to fetch

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; mem_rd=0; mem_addr=0; opcode/operando1/operando2/instReg=0; instr_valid=0; state=FETCH_OP on the next cycle.
- States: FETCH_OP, FETCH_A, FETCH_B, HOLD.
- Memory handshake:
  - In each FETCH_* state, mem_rd=1 and mem_addr=pc, held stable until mem_ready=1.
  - On the ready edge, mem_data is captured and pc increments by 1, wrapping from 2^ADDR_W-1 to 0.
  - mem_ready while mem_rd=0 is ignored.
- Length decode uses the captured opcode[7:6]: 00 → 1 byte; 01 → 2 bytes; 10 or 11 → 3 bytes.
- FETCH_OP, on ready:
  - Capture opcode.
  - Clear operando1 and operando2.
  - Next state FETCH_A if length > 1, else HOLD.
- FETCH_A, on ready: capture operando1; next state FETCH_B if length = 3, else HOLD.
- FETCH_B, on ready: capture operando2; next state HOLD.
- HOLD:
  - mem_rd=0; instr_valid=1; instReg and the byte outputs stable.
  - When instr_ready=1: instr_valid drops next cycle and state=FETCH_OP. The next request is issued the cycle after acceptance.
- Latency (zero-wait memory):
  - 1-byte instruction: valid 1 cycle after the request starts.
  - 3-byte instruction: valid 3 cycles after the request starts.
  - Each memory wait cycle adds 1 cycle.
- instReg is registered and updates only on byte capture, never combinationally from mem_data.
- pc_load=1 in any state:
  - pc=pc_load_value; instr_valid=0; mem_rd=0 that edge; state=FETCH_OP.
  - Partially fetched bytes are discarded. Output byte registers keep their old values but are not valid.
- Simultaneous mem_ready and pc_load: pc_load wins, and the returned byte is dropped.
- Simultaneous instr_ready and pc_load in HOLD: the instruction counts as accepted, and the PC reloads.
- Priority: rst > pc_load > memory/decode handshakes.
- rst mid-fetch: immediate return to reset values, and the in-flight request is abandoned.

Decomposition:
- Shared package holds:
  - the state encoding constants (FETCH_OP=2'd0, FETCH_A=2'd1, FETCH_B=2'd2, HOLD=2'd3);
  - the length-field constants (LEN_1=2'b00, LEN_2=2'b01);
  - the instruction width 3*DATA_W.
- One natural sub-module: instr_len_decode. It is combinational, maps opcode[7:6] to the byte count 1..3, and is reused later by the decoder.
- PC register and byte registers stay in the top module.

Test Plan:
- Reset, then memory at 0x00 = 0x81,0x12,0x34 with mem_ready always 1 and instr_ready=1 → instReg=0x811234, instr_valid pulses one cycle, pc=0x03.
- Memory 0x00=0x05 (1-byte), then 0x01=0x42,0x02=0x7F (2-byte) → instReg=0x050000 then 0x427F00; pc goes 0x01, then 0x03.
- 3-byte fetch with mem_ready low for 2 cycles per byte → mem_addr held during waits, instr_valid rises 9 cycles after the first request, instReg correct.
- instr_ready low for 5 cycles in HOLD → instReg and instr_valid stable, mem_rd=0, pc unchanged until acceptance.
- pc_load=1 with pc_load_value=0x40 during FETCH_A, with mem_ready=1 the same cycle → byte dropped, next mem_addr=0x40, first fetched byte treated as the opcode.
- pc=0xFF fetching a 2-byte instruction → operand read from 0x00, pc=0x01. Then rst asserted mid-FETCH_B → all outputs 0, pc=RESET_PC.
